// File: rtl/mult_div_pkg.sv
// mult_div_pkg
// Shared types and constants for the iterative multiply/divide unit.
//   state_t : control FSM states (IDLE, CALC, SIGN, DONE)
//   op_t    : operation latched on an accepted start (OP_MULT, OP_DIV)
//   WIDTH_DEFAULT : default operand width
package mult_div_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

endpackage

// File: rtl/mdu_cond_neg.sv
// mdu_cond_neg
// Combinational conditional two's-complement negate.
// Used both for operand magnitudes and for the final sign fix-up.
// Ports:
//   in  : value (WIDTH bits)
//   neg : 1 = output the two's complement of in, 0 = pass through
//   out : result (WIDTH bits)
module mdu_cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);

  // Negating the most negative value returns it unchanged; read as
  // unsigned that is exactly its magnitude.
  assign out = neg ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative signed multiply / divide unit feeding the HI/LO registers.
// Multiply is unsigned shift-add on magnitudes, divide is restoring
// shift-subtract on magnitudes; signs are applied in a final SIGN cycle.
// Build option: MULT_DIV_UNSIGNED_EN adds input is_unsigned (multu/divu),
// which suppresses magnitude and negation handling for that operation.
// Ports:
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   start_mult : one-cycle request, signed a*b (wins over start_div)
//   start_div  : one-cycle request, signed a/b
//   is_unsigned: (MULT_DIV_UNSIGNED_EN only) unsigned operation, sampled with start
//   a, b       : operands, sampled on an accepted start
//   hi, lo     : mult {hi,lo} = product; div hi = remainder, lo = quotient
//   busy       : high in CALC and SIGN
//   done       : one-cycle pulse when hi/lo are valid or div_zero is set
//   div_zero   : divide by zero, set with done, cleared on next accepted start
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_mult / start_div
// CALC  | WIDTH iterations of shift-add or shift-subtract
// SIGN  | apply result signs, register hi/lo
// DONE  | done pulse; a new start may be accepted here
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
`ifdef MULT_DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t             state;
  op_t                op;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   opd_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [CW-1:0]      cnt;

  logic               signed_req;
  logic               neg_a_in;
  logic               neg_b_in;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

`ifdef MULT_DIV_UNSIGNED_EN
  assign signed_req = ~is_unsigned;
`else
  assign signed_req = 1'b1;
`endif

  assign neg_a_in = a[WIDTH-1] & signed_req;
  assign neg_b_in = b[WIDTH-1] & signed_req;

  mdu_cond_neg #(.WIDTH(WIDTH)) u_mag_a (.in(a), .neg(neg_a_in), .out(mag_a));
  mdu_cond_neg #(.WIDTH(WIDTH)) u_mag_b (.in(b), .neg(neg_b_in), .out(mag_b));

  // Multiply step: acc holds {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mult_next;

  assign add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd_b} : '0);
  assign mult_next = {add_sum, acc[WIDTH-1:1]};

  // Divide step: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
  // The borrow of the one-bit-wider trial subtract decides restore vs keep.
  logic [WIDTH+1:0]   trial;
  logic               ge;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quot_next;

  assign trial     = {rem, acc[WIDTH-1]} - {2'b00, opd_b};
  assign ge        = ~trial[WIDTH+1];
  assign rem_next  = ge ? trial[WIDTH:0] : {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign quot_next = {acc[WIDTH-2:0], ge};

  // Sign fix-up. The remainder always takes the dividend's sign.
  logic               res_neg;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign res_neg = sign_a ^ sign_b;

  mdu_cond_neg #(.WIDTH(2*WIDTH)) u_fix_prod (.in(acc), .neg(res_neg), .out(prod_fix));
  mdu_cond_neg #(.WIDTH(WIDTH)) u_fix_quot (.in(acc[WIDTH-1:0]), .neg(res_neg), .out(quot_fix));
  mdu_cond_neg #(.WIDTH(WIDTH)) u_fix_rem (.in(rem[WIDTH-1:0]), .neg(sign_a), .out(rem_fix));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op       <= OP_MULT;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      opd_b    <= '0;
      acc      <= '0;
      rem      <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start_mult || start_div) begin
            op     <= start_mult ? OP_MULT : OP_DIV;
            sign_a <= neg_a_in;
            sign_b <= neg_b_in;
            opd_b  <= mag_b;
            acc    <= {{WIDTH{1'b0}}, mag_a};
            rem    <= '0;
            cnt    <= '0;
            if (!start_mult && (b == '0)) begin
              // Divide by zero: skip straight to DONE, hi/lo untouched.
              div_zero <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              div_zero <= 1'b0;
              busy     <= 1'b1;
              state    <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end

        CALC: begin
          if (op == OP_MULT) begin
            acc <= mult_next;
          end else begin
            rem             <= rem_next;
            acc[WIDTH-1:0]  <= quot_next;
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= SIGN;
          end
        end

        SIGN: begin
          if (op == OP_MULT) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start_mult;
  logic         start_div;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_zero;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sb_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
`ifdef MULT_DIV_UNSIGNED_EN
    .is_unsigned(1'b0),
`endif
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Reference: plain signed 64-bit arithmetic. SV division truncates toward
  // zero and % takes the dividend's sign, which is the MIPS behaviour.
  function automatic exp_t model(input bit is_mult, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint sx;
    longint sy;
    longint p;
    longint q;
    longint r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (is_mult) begin
      p    = sx * sy;
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.dz = 1'b0;
    end else if (y == '0) begin
      e.hi = model_hi;
      e.lo = model_lo;
      e.dz = 1'b1;
    end else begin
      q    = sx / sy;
      r    = sx % sy;
      e.hi = r[31:0];
      e.lo = q[31:0];
      e.dz = 1'b0;
    end
    model_hi = e.hi;
    model_lo = e.lo;
    return e;
  endfunction

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done with hi=%0h lo=%0h, expected no result", hi, lo);
      end else begin
        e = sb_q.pop_front();
        check("result_hi", hi, e.hi);
        check("result_lo", lo, e.lo);
        check("result_div_zero", div_zero, e.dz);
      end
    end
  end

  // One operation. both=1 raises both starts; inject_at>0 pulses a stray
  // start_div (with b=0) that many cycles into the operation.
  task automatic do_op(input bit is_mult, input bit both, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int inject_at);
    int edges;
    int busy_cnt;
    bit eff_mult;
    bit dz_case;
    eff_mult = is_mult || both;
    dz_case  = !eff_mult && (y == '0);
    sb_q.push_back(model(eff_mult, x, y));
    @(negedge clock);
    a          = x;
    b          = y;
    start_mult = eff_mult;
    start_div  = !is_mult || both;
    @(negedge clock);
    start_mult = 1'b0;
    start_div  = 1'b0;
    a          = $urandom;
    b          = $urandom;
    edges      = 1;
    busy_cnt   = 0;
    check("start_busy", busy, !dz_case);
    check("start_div_zero", div_zero, dz_case);
    while (!done && edges < 100) begin
      if (busy) busy_cnt++;
      if (edges == inject_at) begin
        start_div = 1'b1;
        a         = $urandom;
        b         = '0;
      end
      @(negedge clock);
      start_div = 1'b0;
      edges++;
    end
    check("latency", edges, dz_case ? 1 : 34);
    check("busy_cycles", busy_cnt, dz_case ? 0 : 33);
    repeat (2) @(negedge clock);
    check("hold_hi", hi, model_hi);
    check("hold_lo", lo, model_lo);
    check("done_cleared", done, 1'b0);
  endtask

  task automatic reset_mid_calc(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clock);
    a          = x;
    b          = y;
    start_mult = 1'b1;
    @(negedge clock);
    start_mult = 1'b0;
    repeat (14) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_hi", hi, '0);
    check("async_rst_lo", lo, '0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_operand(input bit allow_zero);
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'h8000_0000;
    if (sel == 1) return 32'hFFFF_FFFF;
    if (sel == 2) return allow_zero ? 32'h0 : 32'h1;
    if (sel <= 4) return W'($urandom_range(1, 300)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h1);
    return $urandom;
  endfunction

  initial begin
    reset      = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a          = '0;
    b          = '0;
    repeat (3) @(negedge clock);
    check("reset_hi", hi, '0);
    check("reset_lo", lo, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_div_zero", div_zero, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -1);
    do_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, -1);
    do_op(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFE, -1);
    do_op(1'b0, 1'b0, 32'd47, 32'd7, -1);
    do_op(1'b0, 1'b0, 32'd1234, 32'd0, -1);
    do_op(1'b1, 1'b0, 32'd3, 32'd5, -1);
    do_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1);
    do_op(1'b1, 1'b0, $urandom, $urandom, 10);
    do_op(1'b0, 1'b1, $urandom, $urandom, -1);

    reset_mid_calc(32'h1234_5678, 32'h9ABC_DEF0);
    do_op(1'b1, 1'b0, 32'hFFFF_FF00, 32'h0000_0123, -1);

    for (int i = 0; i < 50; i++) begin
      do_op($urandom_range(0, 1) == 1, 1'b0, pick_operand(1'b1), pick_operand(1'b1), -1);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
